// File: rtl/capp_uart_pkg.sv
// ---------------------------------------------------------------------------
// capp_uart_pkg
// Shared definitions for the UART transmit scheduler:
//   - default sizing (number of sources, message length, length-field width)
//   - FSM state constants (ST_IDLE, ST_SEND)
//   - byte-select helper used to pick one character out of a packed message
// No ports (package).
// ---------------------------------------------------------------------------
package capp_uart_pkg;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_MSG_LEN = 32;
    localparam int DEF_LEN_W   = 6;

    // Source index width; grant_id is fixed at 3 bits, enough for 8 sources.
    localparam int ID_W = 3;

    // Scheduler FSM states.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Bit offset of byte number byte_idx inside a packed message.
    // Callers shift the message right by this amount and keep the low 8 bits.
    function automatic int byte_shift(input int byte_idx);
        return 8 * byte_idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search starts one above the
// pointer (the last winner) and wraps, so the last winner has lowest priority.
// Ports:
//   req_i   [NUM_REQ-1:0]  request vector
//   ptr_i   [ID_W-1:0]     index of the previous winner
//   grant_o [NUM_REQ-1:0]  one-hot grant (all zero when no request)
//   idx_o   [ID_W-1:0]     index of the granted request (0 when none)
//   any_o                  at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import capp_uart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    // Two passes: first the indices above the pointer, then the wrapped ones
    // at or below it. The first hit in that order wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!any_o && req_i[j] && (j > int'(ptr_i))) begin
                grant_o[j] = 1'b1;
                idx_o      = ID_W'(j);
                any_o      = 1'b1;
            end else begin
                grant_o[j] = grant_o[j];
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!any_o && req_i[j] && (j <= int'(ptr_i))) begin
                grant_o[j] = 1'b1;
                idx_o      = ID_W'(j);
                any_o      = 1'b1;
            end else begin
                grant_o[j] = grant_o[j];
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one byte-wide transmit stream between NUM_REQ message sources.
// A source is granted round-robin, its whole message is latched, and the
// message is sent byte by byte, last-packed character (byte len-1) first.
// Messages never interleave.
// Ports:
//   clk_48mhz                    clock
//   reset_n                      asynchronous active-low reset
//   req_valid [NUM_REQ]          source i has a message
//   req_ready [NUM_REQ]          one-hot accept (combinational, idle only)
//   req_data  [NUM_REQ*8*MSG_LEN] source i message at [i*8*MSG_LEN +: 8*MSG_LEN]
//   req_len   [NUM_REQ*LEN_W]    source i byte count at [i*LEN_W +: LEN_W]
//   tx_data   [8]                byte to the UART
//   tx_valid                     byte valid to the UART
//   tx_ready                     UART accepts the byte
//   busy                         a message is latched and not fully sent
//   grant_id  [3]                source owning the current/last message
// ---------------------------------------------------------------------------
module uart_tx_scheduler
    import capp_uart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int MSG_LEN = DEF_MSG_LEN,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                       clk_48mhz,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*8*MSG_LEN-1:0] req_data,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic [2:0]                 grant_id
);

    localparam int MSG_W = 8 * MSG_LEN;

    logic [0:0]         state_q,    state_d;
    logic [MSG_W-1:0]   buf_q,      buf_d;
    logic [LEN_W-1:0]   rem_q,      rem_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q,  tx_data_d;
    logic               busy_q,     busy_d;
    logic [ID_W-1:0]    grant_q,    grant_d;
    logic [ID_W-1:0]    ptr_q,      ptr_d;

    logic [NUM_REQ-1:0] arb_grant_s;
    logic [ID_W-1:0]    arb_idx_s;
    logic               arb_any_s;
    logic [MSG_W-1:0]   win_msg_s;
    logic [LEN_W-1:0]   win_len_s;
    logic [LEN_W-1:0]   len_eff_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant_s),
        .idx_o   (arb_idx_s),
        .any_o   (arb_any_s)
    );

    // Select the winning source's message and length.
    always_comb begin
        win_msg_s = '0;
        win_len_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant_s[i]) begin
                win_msg_s = req_data[i*MSG_W +: MSG_W];
                win_len_s = req_len[i*LEN_W +: LEN_W];
            end else begin
                win_len_s = win_len_s;
            end
        end
    end

    // Oversized lengths are clamped to the buffer size.
    assign len_eff_s = (win_len_s > LEN_W'(MSG_LEN)) ? LEN_W'(MSG_LEN) : win_len_s;

    // Accept is offered only while idle and out of reset.
    assign req_ready = ((state_q == ST_IDLE) && reset_n) ? arb_grant_s : '0;

    // Next-state logic: accept in IDLE, byte stepping in SEND.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        rem_d      = rem_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any_s) begin
                    ptr_d   = arb_idx_s;
                    grant_d = arb_idx_s;
                    buf_d   = win_msg_s;
                    if (len_eff_s != '0) begin
                        // First byte is loaded straight from the source so it
                        // appears the cycle after accept.
                        rem_d      = len_eff_s;
                        state_d    = ST_SEND;
                        tx_valid_d = 1'b1;
                        busy_d     = 1'b1;
                        tx_data_d  = 8'(win_msg_s >> byte_shift(int'(len_eff_s) - 1));
                    end else begin
                        // Empty message: consumed without sending anything.
                        rem_d = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (rem_q == LEN_W'(1)) begin
                        state_d    = ST_IDLE;
                        tx_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        rem_d      = '0;
                    end else begin
                        // rem_q >= 2 here, so the next byte index rem_q-2 is valid.
                        rem_d     = rem_q - LEN_W'(1);
                        tx_data_d = 8'(buf_q >> byte_shift(int'(rem_q) - 2));
                    end
                end else begin
                    tx_data_d = tx_data_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                rem_d      = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            rem_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            grant_q    <= '0;
            ptr_q      <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            rem_q      <= rem_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Directed and randomized stimulus for uart_tx_scheduler (NUM_REQ=2,
// MSG_LEN=32). A negedge monitor keeps a reference model: round-robin
// winner prediction, expected byte stream built from accepted messages,
// busy/latency/gap expectations and stall-hold checks.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int NR = 2;
    localparam int ML = 32;
    localparam int LW = 6;
    localparam int MW = 8 * ML;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [MW-1:0]   src_data [NR];
    logic [LW-1:0]   src_len  [NR];
    logic [NR*MW-1:0] req_data;
    logic [NR*LW-1:0] req_len;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            busy;
    logic [2:0]      grant_id;

    int checks   = 0;
    int failures = 0;

    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int         acc_q [$];

    // Reference model state (updated in the monitor).
    logic [NR-1:0] acc_flag = '0;
    int            mptr = NR - 1;
    int            mrem = 0;
    bit            expect_first = 1'b0;
    bit            expect_gap   = 1'b0;
    int            expect_gid   = -1;
    bit            prev_stall   = 1'b0;
    logic [7:0]    prev_data    = 8'h00;
    int            mw;
    int            mle;
    logic [NR-1:0] exp_rdy;

    always #5 clk = ~clk;

    assign req_data = {src_data[1], src_data[0]};
    assign req_len  = {src_len[1], src_len[0]};

    uart_tx_scheduler dut (
        .clk_48mhz (clk),
        .reset_n   (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_len   (req_len),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first valid source after the last winner, wrapping.
    function automatic int pred_winner(input logic [NR-1:0] v, input int ptr);
        for (int k = 1; k <= NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    // Monitor and reference model, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mptr = NR - 1; mrem = 0; expect_first = 1'b0; expect_gap = 1'b0;
            expect_gid = -1; prev_stall = 1'b0; acc_flag = '0;
        end else begin
            chk("busy", 32'(busy), 32'(mrem != 0));
            if (expect_first) chk("first_latency", 32'(tx_valid), 32'd1);
            if (expect_gap) chk("idle_gap", 32'(tx_valid), 32'd0);
            if (expect_gid >= 0) chk("grant_id", 32'(grant_id), 32'(expect_gid));
            if (prev_stall) chk("tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, prev_data}));
            expect_first = 1'b0; expect_gap = 1'b0; expect_gid = -1;
            mw = pred_winner(req_valid, mptr);
            exp_rdy = (mw < 0 || busy) ? '0 : NR'(1 << mw);
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            acc_flag = req_valid & req_ready;
            if (exp_rdy != '0) begin
                mptr = mw;
                expect_gid = mw;
                acc_q.push_back(mw);
                mle = (int'(src_len[mw]) > ML) ? ML : int'(src_len[mw]);
                for (int b = mle - 1; b >= 0; b--) exp_q.push_back(src_data[mw][8*b +: 8]);
                if (mle > 0) begin
                    mrem = mle;
                    expect_first = 1'b1;
                end
            end
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                if (mrem > 0) begin
                    mrem--;
                    if (mrem == 0) expect_gap = 1'b1;
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic set_msg(input int src, input string s);
        src_data[src] = '0;
        src_len[src]  = LW'(s.len());
        for (int k = 0; k < s.len(); k++) src_data[src][8*(s.len()-1-k) +: 8] = s[k];
    endtask

    task automatic rand_msg(input int src);
        src_len[src] = LW'($urandom_range(0, 40));
        for (int w = 0; w < MW/32; w++) src_data[src][32*w +: 32] = $urandom;
    endtask

    // One clock: sources drop valid once their message was accepted.
    task automatic step();
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) if (acc_flag[i]) req_valid[i] = 1'b0;
    endtask

    task automatic step_rand();
        @(posedge clk); #1;
        tx_ready = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < NR; i++) begin
            if (acc_flag[i]) req_valid[i] = 1'b0;
            else if (!req_valid[i]) begin
                if ($urandom_range(0, 5) == 0) begin rand_msg(i); req_valid[i] = 1'b1; end
            end else if ($urandom_range(0, 99) == 0) req_valid[i] = 1'b0;
        end
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((req_valid != '0 || busy || tx_valid) && n < max_cyc) begin step(); n++; end
        chk("drain_done", 32'(req_valid == '0 && !busy && !tx_valid), 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete(); exp_q.delete();
    endtask

    task automatic reset_apply(input logic [NR-1:0] v);
        rst_n = 1'b0; req_valid = v; tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        got_q.delete(); exp_q.delete(); acc_q.delete();
    endtask

    initial begin
        logic [7:0] t1_exp [4];
        int n;
        int cnt_r;
        int cnt_v;
        bit reissued;
        logic pat [4];
        t1_exp[0] = 8'h4F; t1_exp[1] = 8'h4B; t1_exp[2] = 8'h0D; t1_exp[3] = 8'h0A;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        src_data[0] = '0; src_data[1] = '0; src_len[0] = '0; src_len[1] = '0;
        reset_apply(2'b00);

        // 1: "OK\r\n" from src0 with tx_ready held high.
        set_msg(0, "OK\r\n");
        req_valid = 2'b01;
        @(negedge clk);
        chk("t1_req_ready", 32'(req_ready), 32'd1);
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_valid", 32'(tx_valid), 32'd1);
            chk("t1_byte", 32'(tx_data), 32'(t1_exp[k]));
        end
        @(negedge clk);
        chk("t1_end_valid", 32'(tx_valid), 32'd0);
        chk("t1_end_busy", 32'(busy), 32'd0);
        compare_stream("t1");

        // 2: both valid from reset; src0 re-requests while its first message is sent.
        set_msg(0, "AAA");
        set_msg(1, "BB");
        reset_apply(2'b11);
        reissued = 1'b0; n = 0;
        while ((req_valid != '0 || busy || tx_valid || !reissued) && n < 400) begin
            step();
            if (acc_flag[0] && !reissued) begin
                set_msg(0, "CCCC"); req_valid[0] = 1'b1; reissued = 1'b1;
            end
            n++;
        end
        chk("t2_accepts", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() == 3) begin
            chk("t2_order0", 32'(acc_q[0]), 32'd0);
            chk("t2_order1", 32'(acc_q[1]), 32'd1);
            chk("t2_order2", 32'(acc_q[2]), 32'd0);
        end
        compare_stream("t2");

        // 3: 22-byte banner with tx_ready pattern 1-0-0-1.
        set_msg(0, "CAPP-UART BANNER v1.2\n");
        req_valid = 2'b01;
        n = 0;
        while ((req_valid != '0 || busy || tx_valid) && n < 400) begin
            step(); tx_ready = pat[n % 4]; n++;
        end
        tx_ready = 1'b1;
        chk("t3_count", 32'(got_q.size()), 32'd22);
        compare_stream("t3");

        // 4: zero-length message, then an oversized one (40 -> 32 bytes).
        set_msg(1, "Z"); src_len[1] = '0;
        req_valid = 2'b10;
        @(negedge clk);
        chk("t4_ready", 32'(req_ready), 32'd2);
        cnt_r = int'(req_ready[1]); cnt_v = 0;
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cnt_r += int'(req_ready[1]); cnt_v += int'(tx_valid);
        end
        chk("t4_ready_once", 32'(cnt_r), 32'd1);
        chk("t4_no_tx", 32'(cnt_v), 32'd0);
        chk("t4_grant", 32'(grant_id), 32'd1);
        rand_msg(0); src_len[0] = LW'(40);
        req_valid = 2'b01;
        drain(400);
        chk("t4_clamp", 32'(got_q.size()), 32'd32);
        compare_stream("t4");

        // 5: reset after 3 of 18 bytes, then a fresh message.
        set_msg(1, "0123456789ABCDEFGH");
        req_valid = 2'b10;
        n = 0;
        while (got_q.size() < 3 && n < 50) begin step(); n++; end
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(tx_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_sent", 32'(got_q.size()), 32'd3);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        compare_stream("t5_pre");
        req_valid = '0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_msg(0, "NEW!");
        req_valid = 2'b01;
        drain(200);
        chk("t5_count", 32'(got_q.size()), 32'd4);
        compare_stream("t5_post");

        // 6: randomized requests, lengths, withdrawals and stalls.
        for (int c = 0; c < 10000; c++) step_rand();
        tx_ready = 1'b1;
        drain(2000);
        compare_stream("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
